// File: rtl/uno_seq.sv
// Upstream sequencer for the unified PE: turns operand beats into cycle-by-cycle
// uno control (MAC streams or Horner evaluations) and returns the captured result.
module uno_seq #(
  parameter int MAC_BW  = 16,
  parameter int NCOEF   = 4,
  parameter int LUT_LAT = 1,
  parameter int MAC_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [MAC_BW-1:0]     in_x,
  input  logic [MAC_BW-1:0]     in_y,
  input  logic [2*MAC_BW-1:0]   in_z,
  input  logic                  in_last,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*MAC_BW+3:0]   res_data,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_op,
  input  logic [2:0]            cfg_idx,
  input  logic [MAC_BW-1:0]     cfg_data,
  output logic                  cfg_err,
  output logic [1:0]            uno_op,
  output logic [MAC_BW-1:0]     uno_x,
  output logic [MAC_BW-1:0]     uno_y,
  output logic [2*MAC_BW-1:0]   uno_z,
  output logic [MAC_BW-1:0]     uno_coeff,
  output logic                  uno_first_cycle,
  output logic                  uno_last_cycle,
  output logic                  uno_acc_en,
  input  logic [2*MAC_BW+3:0]   uno_out
);

  typedef enum logic [2:0] {IDLE, MSTREAM, WARM, RUN, DRAIN, DONE} state_t;

  localparam logic [2:0] KLAST = 3'(NCOEF - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [2:0]        k;
  logic [2:0]        k_nx;
  logic              accept;
  logic              cfg_ok;
  // Bank 0 (MAC) is never written; the table is sized to the full index range.
  logic [MAC_BW-1:0] tab [0:3][0:7];

  assign accept = in_valid & in_ready;
  assign k_nx   = k + 3'd1;
  assign cfg_ok = (state == IDLE) && (cfg_op != 2'b00) && ({1'b0, cfg_idx} < 4'(NCOEF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      k               <= '0;
      in_ready        <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      cfg_err         <= 1'b0;
      uno_op          <= '0;
      uno_x           <= '0;
      uno_y           <= '0;
      uno_z           <= '0;
      uno_coeff       <= '0;
      uno_first_cycle <= 1'b0;
      uno_last_cycle  <= 1'b0;
      uno_acc_en      <= 1'b0;
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 8; i++)
          tab[b][i] <= '0;
    end else begin
      // Table write lands before any same-cycle beat reads it in later states.
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if (cfg_ok) tab[cfg_op][cfg_idx] <= cfg_data;
        else        cfg_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            uno_x           <= in_x;
            uno_coeff       <= '0;
            uno_first_cycle <= 1'b0;
            uno_last_cycle  <= 1'b0;
            uno_acc_en      <= 1'b0;
            if (in_op == 2'b00) begin
              uno_op <= 2'b00;
              uno_y  <= in_y;
              uno_z  <= in_z;
              if (in_last) begin
                in_ready <= 1'b0;
                cnt      <= 4'(MAC_LAT);
                state    <= DRAIN;
              end else begin
                state <= MSTREAM;
              end
            end else begin
              uno_op   <= in_op;
              uno_y    <= (in_op == 2'b01) ? in_y : '0;
              uno_z    <= '0;
              in_ready <= 1'b0;
              cnt      <= 4'(LUT_LAT - 1);
              state    <= WARM;
            end
          end
        end

        MSTREAM: begin
          uno_op     <= 2'b00;
          uno_z      <= '0;
          uno_acc_en <= 1'b1;
          if (accept) begin
            uno_x <= in_x;
            uno_y <= in_y;
            if (in_last) begin
              in_ready <= 1'b0;
              cnt      <= 4'(MAC_LAT);
              state    <= DRAIN;
            end
          end else begin
            // Bubble: zero product keeps the accumulator unchanged.
            uno_x <= '0;
            uno_y <= '0;
          end
        end

        WARM: begin
          if (cnt == 4'd0) begin
            k               <= 3'd0;
            uno_coeff       <= tab[uno_op][3'd0];
            uno_first_cycle <= 1'b1;
            uno_last_cycle  <= (KLAST == 3'd0);
            state           <= RUN;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RUN: begin
          uno_first_cycle <= 1'b0;
          if (k == KLAST) begin
            uno_coeff      <= '0;
            uno_last_cycle <= 1'b0;
            cnt            <= 4'(MAC_LAT - 1);
            state          <= DRAIN;
          end else begin
            k              <= k_nx;
            uno_coeff      <= tab[uno_op][k_nx];
            uno_last_cycle <= (k_nx == KLAST);
          end
        end

        DRAIN: begin
          // MAC drain spans the last beat plus MAC_LAT hold cycles.
          if (uno_op == 2'b00) begin
            uno_x      <= '0;
            uno_y      <= '0;
            uno_z      <= '0;
            uno_acc_en <= 1'b1;
          end
          if (cnt == 4'd0) begin
            res_data        <= uno_out;
            res_valid       <= 1'b1;
            uno_op          <= '0;
            uno_x           <= '0;
            uno_y           <= '0;
            uno_z           <= '0;
            uno_coeff       <= '0;
            uno_first_cycle <= 1'b0;
            uno_last_cycle  <= 1'b0;
            uno_acc_en      <= 1'b0;
            state           <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        DONE: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uno_seq.md
Name: uno_seq

Overview:
- Upstream sequencer for the unified PE `uno` (MAC, div, exp, log).
- Accepts operand beats over a valid/ready stream and registers them, then drives every `uno` input cycle by cycle: op, X, Y, Z, coeff, first/last-cycle flags and acc_en.
- Captures `uno.out` when the result is valid and returns it over a second valid/ready stream.
- Holds a programmable table of polynomial coefficients, one set per nonlinear op.

Parameters:
- MAC_BW, 16, operand width; must equal the codebase `MAC_BW`.
- NCOEF, 4, Horner steps per div/exp/log evaluation; range 2..8.
- LUT_LAT, 1, cycles between presenting X and the registered exp/log LUT outputs becoming valid.
- MAC_LAT, 1, cycles from a `uno` input set to the matching `uno.out` value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_op  in  2  operation: 00 MAC, 01 div, 10 exp, 11 log.
- in_x  in  MAC_BW  operand X.
- in_y  in  MAC_BW  operand Y; for MAC only.
- in_z  in  2*MAC_BW  MAC initial addend; used on the first beat of a group only.
- in_last  in  1  MAC op only: last beat of the accumulation group.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid & res_ready.
- res_data  out  2*MAC_BW+4  captured `uno.out`.
- cfg_we  in  1  coefficient table write strobe.
- cfg_op  in  2  table bank; 01, 10 or 11 (writes to 00 are ignored).
- cfg_idx  in  3  step index; must be < NCOEF.
- cfg_data  in  MAC_BW  coefficient value.
- cfg_err  out  1  one-cycle pulse when a write is dropped.
- uno_op  out  2  to `uno.op`.
- uno_x, uno_y  out  MAC_BW  to `uno.X` and `uno.Y`.
- uno_z  out  2*MAC_BW  to `uno.Z`.
- uno_coeff  out  MAC_BW  to `uno.coeff`.
- uno_first_cycle, uno_last_cycle, uno_acc_en  out  1  to `uno` (the first-cycle flag maps to `uno.fisrt_cycle`).
- uno_out  in  2*MAC_BW+4  from `uno.out`.

Behaviour:
- Reset values: all outputs 0, including in_ready; state IDLE; coefficient table all 0. in_ready rises on the first cycle after reset is released.
- Reset mid-operation: abort at once, any pending result is lost, outputs return to their reset values.
- All `uno_*` outputs are registered. A beat accepted at cycle t is presented to `uno` at cycle t+1.
- State IDLE:
  - in_ready = 1.
  - Accepted beat with in_op=00 → state MSTREAM.
  - Accepted beat with any other op → state WARM.
- State MSTREAM (MAC op):
  - Each accepted beat drives uno_x/uno_y from the beat and uno_op=00.
  - uno_acc_en = 0 on the first beat of a group (uno_z = in_z). On later beats uno_acc_en = 1 and uno_z = 0.
  - Bubble cycle (no beat accepted): drive uno_x=0, uno_y=0, uno_acc_en=1 so the accumulator holds.
  - Beat with in_last accepted → in_ready=0 → state DRAIN.
- State WARM (div/exp/log):
  - Operands are latched from the beat. uno_op=in_op, uno_x=in_x; uno_y=in_y for div, otherwise 0.
  - coeff=0, first=0, last=0.
  - Stays LUT_LAT cycles → state RUN.
- State RUN:
  - Step counter k runs 0..NCOEF-1.
  - uno_coeff = tab[op][k]; uno_first_cycle = (k==0); uno_last_cycle = (k==NCOEF-1).
  - X, Y and op are held stable throughout.
  - After k = NCOEF-1 → state DRAIN.
- State DRAIN:
  - Waits MAC_LAT cycles with uno_first_cycle, uno_last_cycle and uno_coeff at 0, and uno_acc_en held (1 for MAC op).
  - On its final cycle, uno_out is registered into res_data → state DONE.
- State DONE:
  - res_valid = 1; res_data stays stable until accepted.
  - in_ready = 0.
  - On res_valid & res_ready → state IDLE; in_ready may be 1 the next cycle.
- Latency (defaults):
  - Nonlinear op: accept at t, res_valid at t+3+NCOEF = t+7.
  - MAC op: res_valid 2+MAC_LAT cycles after acceptance of the in_last beat, i.e. t+3.
- Single-beat MAC group (first beat also has in_last): result = X*Y+Z.
- Config writes:
  - Accepted only in IDLE. A write in any other state, with cfg_idx >= NCOEF, or with cfg_op=00 is dropped and pulses cfg_err the next cycle.
  - cfg_we and an in_valid accept in the same IDLE cycle: the write lands first, so the new coefficient is used by that operation.
- in_valid & in_ready with in_last while the op is not MAC: in_last is ignored.
- The op of a MAC group is fixed by its first beat. A later beat in the group with in_op≠00 is accepted as MAC.

Test Plan:
- MAC group: beats (X=2,Y=3,Z=5), (4,5), (1,1,last), back-to-back, res_ready=1 → res_data=32; res_valid exactly 3 cycles after the last beat is accepted.
- Same group with 2 idle cycles between beats → bubbles drive uno_x=uno_y=0 with uno_acc_en=1; res_data=32.
- Program tab[10] = {0x1000, 0x0800, 0x0200, 0x0055}, then issue an exp beat at t=0:
  - uno_coeff equals those values on cycles 2..5; uno_first_cycle high on cycle 2 only; uno_last_cycle high on cycle 5 only.
  - res_valid at cycle 7 with res_data equal to uno_out sampled at cycle 6.
- Hold res_ready=0 for 5 cycles in DONE → res_valid, res_data and in_ready=0 all stable; beat accepted 1 cycle after the handshake completes.
- Pulse rst_n low during RUN at k=2 → all outputs 0 immediately; after release, a fresh div op completes normally with the retained-zero table.
- cfg_we during RUN, or with cfg_idx=5 → table unchanged, cfg_err high for exactly 1 cycle.
